uart_key_decoder: RTL and testbench
===================================

Name: uart_key_decoder

Overview:
Consumer stage directly downstream of the UART receiver. It takes each received ASCII byte and turns it into registered game controls: two paddle direction pairs (up/down per player), a serve pulse and a pause level. A UART keyboard stream carries no key-release events, so each direction press is held for a programmable number of frame ticks and then expires. The 4-bit direction bus feeds the paddle logic directly.

Parameters:
HOLD_TICKS, 6, frame ticks a direction stays asserted after its most recent key byte (must be >= 1).
CNT_W, 4, hold-counter width (must satisfy 2^CNT_W > HOLD_TICKS).

Ports:
clk  input  1  system clock (same domain as the UART receiver output).
reset  input  1  asynchronous, active-high reset.
rx_data  input  8  received byte; valid only while rx_valid=1.
rx_valid  input  1  one-clk strobe marking a new byte; the upstream rising-edge detector guarantees it.
tick  input  1  one-clk frame-rate strobe (about 60 Hz).
di  output  4  {p2_dn, p2_up, p1_dn, p1_up}; registered.
serve  output  1  one-clk pulse on a serve key.
paused  output  1  pause level; registered.
last_key  output  8  last byte that decoded to a valid command; registered.

Behaviour:
- Reset (asynchronous, active-high): di=0, serve=0, paused=0, last_key=8'h00, both hold counters 0, both paddle FSMs IDLE.
- Key decode (case-insensitive; all other bytes are ignored and leave all state unchanged):
  - 'w'/'W' (77/57): P1 up. 's'/'S' (73/53): P1 down.
  - 'i'/'I' (69/49): P2 up. 'k'/'K' (6B/4B): P2 down.
  - space (20): serve. 'p'/'P' (70/50): toggle pause.
- Per-paddle FSM, states IDLE, UP, DN, each with a CNT_W-bit counter:
  - Same-paddle key in any state: go to the matching state and load the counter with HOLD_TICKS. A repeat press extends the hold; the opposite key reverses direction immediately.
  - tick while in UP/DN with counter > 1: decrement.
  - tick with counter == 1: counter goes to 0 and the FSM returns to IDLE.
  - tick while IDLE: no effect.
- Simultaneous rx_valid (valid paddle key) and tick on the same clk: the load wins and the tick is discarded for that paddle only. The other paddle still decrements.
- di bits: up=1 only in UP, dn=1 only in DN. up and dn are never both 1.
- Latency:
  - rx_valid at edge N → di/serve/paused/last_key updated at edge N+1.
  - Expiry tick at edge M → di bit clears at edge M+1.
- Hold length: after a press, the direction stays asserted through exactly HOLD_TICKS tick strobes and clears after the HOLD_TICKS-th.
- Pause:
  - 'p' toggles paused.
  - Entering pause forces both FSMs to IDLE and clears both counters on the same edge.
  - While paused, all keys except 'p' are ignored (no di, no serve, last_key unchanged); ticks have no effect.
- serve pulses high for exactly one clk per accepted space byte and is never asserted while paused.
- last_key is updated on every accepted command byte, including 'p' in either direction.
- Reset mid-hold: all outputs clear immediately (asynchronously), not at the next clock edge.
- rx_valid held high for multiple clks is out of contract; each high clk is treated as a separate byte.

Test Plan:
- Reset released; rx 'w' (77) at cycle 10 → di=4'b0001 at cycle 11, last_key=77. Then 6 ticks → di=0 one clk after the 6th tick; still 1 after the 5th.
- rx 'i', then rx 'K' two ticks later → di: 0100 then 1000, and the counter reloads (1000 holds for 6 more ticks). 'W' concurrently keeps 0001 set independently (di=1001).
- rx 's' on the same clk as tick with P2 in UP, counter=3 → P1 DN loaded to 6 (no decrement); P2 counter → 2.
- rx 'p' while di=0101 → paused=1, di=0000 next clk. rx 'w', ' ' and ticks → no change, serve stays 0. rx 'P' → paused=0, last_key=50.
- rx ' ' (20) unpaused → serve high for exactly 1 clk. rx 'x' (78), 0x00, 0xFF → no output change, last_key unchanged.
- Assert reset asynchronously mid-hold (di=0010) → di=0, paused=0, last_key=0 before the next clk edge. After release, ticks alone keep di=0.

Source files
------------

// File: rtl/uart_key_if.sv
// Bundle between the UART receiver/frame timer and the key decoder.
// The master drives bytes and ticks; the decoder (slave) drives the game controls.
interface uart_key_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tick;
  logic [3:0] di;
  logic       serve;
  logic       paused;
  logic [7:0] last_key;

  modport master (
    output rx_data, rx_valid, tick,
    input  di, serve, paused, last_key
  );

  modport slave (
    input  rx_data, rx_valid, tick,
    output di, serve, paused, last_key
  );
endinterface

// File: rtl/uart_key_decoder.sv
// Turns received ASCII bytes into paddle directions, a serve pulse and a pause level.
// UART keyboards send no release events, so each direction expires after HOLD_TICKS frame ticks.
module uart_key_decoder #(
  parameter int HOLD_TICKS = 6,
  parameter int CNT_W      = 4
) (
  input  logic     clk,
  input  logic     reset,
  uart_key_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DN   = 2'd2
  } paddle_state_t;

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_TICKS);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic       paused_q, paused_d;
  logic       serve_q, serve_d;
  logic [3:0] di_q, di_d;
  logic [7:0] last_key_q, last_key_d;

  logic [1:0] up_key, dn_key;
  logic       is_space, is_p, is_paddle;
  logic       pause_enter;
  logic [1:0] is_up_d, is_dn_d;

  // Raw byte classification; paddle keys are indexed by player (0 = P1, 1 = P2).
  always_comb begin
    up_key    = 2'b00;
    dn_key    = 2'b00;
    is_space  = 1'b0;
    is_p      = 1'b0;
    case (bus.rx_data)
      8'h77, 8'h57: up_key[0] = 1'b1;
      8'h73, 8'h53: dn_key[0] = 1'b1;
      8'h69, 8'h49: up_key[1] = 1'b1;
      8'h6B, 8'h4B: dn_key[1] = 1'b1;
      8'h20:        is_space  = 1'b1;
      8'h70, 8'h50: is_p      = 1'b1;
      default: ;
    endcase
    // Only 'p' gets through while paused.
    if (!bus.rx_valid || paused_q) begin
      up_key   = 2'b00;
      dn_key   = 2'b00;
      is_space = 1'b0;
    end
    if (!bus.rx_valid) begin
      is_p = 1'b0;
    end
  end

  assign is_paddle   = |{up_key, dn_key};
  assign pause_enter = is_p && !paused_q;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_paddle
      paddle_state_t    state_q, state_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;

      // A key load takes priority over a tick on the same clock for this paddle.
      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (pause_enter) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (!paused_q) begin
          if (up_key[gi]) begin
            state_d = ST_UP;
            cnt_d   = HOLD_LOAD;
          end else if (dn_key[gi]) begin
            state_d = ST_DN;
            cnt_d   = HOLD_LOAD;
          end else if (bus.tick && state_q != ST_IDLE) begin
            if (cnt_q <= CNT_ONE) begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
        end
      end

      assign is_up_d[gi] = (state_d == ST_UP);
      assign is_dn_d[gi] = (state_d == ST_DN);
    end
  endgenerate

  always_comb begin
    di_d       = {is_dn_d[1], is_up_d[1], is_dn_d[0], is_up_d[0]};
    serve_d    = is_space;
    paused_d   = paused_q ^ is_p;
    last_key_d = last_key_q;
    if (is_p || is_space || is_paddle) begin
      last_key_d = bus.rx_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      di_q       <= 4'b0000;
      serve_q    <= 1'b0;
      paused_q   <= 1'b0;
      last_key_q <= 8'h00;
    end else begin
      di_q       <= di_d;
      serve_q    <= serve_d;
      paused_q   <= paused_d;
      last_key_q <= last_key_d;
    end
  end

  assign bus.di       = di_q;
  assign bus.serve    = serve_q;
  assign bus.paused   = paused_q;
  assign bus.last_key = last_key_q;

endmodule

// File: tb/tb_uart_key_decoder.sv
// Directed bench for uart_key_decoder: hold/expiry, reversal, key/tick collision,
// pause gating, serve pulse, ignored bytes and asynchronous reset.
module tb_uart_key_decoder;
  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  uart_key_if bus ();

  uart_key_decoder #(.HOLD_TICKS(6), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock with the given strobes; returns 1 time unit after the edge.
  task automatic step(input logic [7:0] b, input logic v, input logic t);
    bus.rx_data  = b;
    bus.rx_valid = v;
    bus.tick     = t;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    bus.tick     = 1'b0;
    $display("[TB] t=%0t rx=%0b data=%h tick=%0b -> di=%b serve=%0b paused=%0b last_key=%h",
             $time, v, b, t, bus.di, bus.serve, bus.paused, bus.last_key);
  endtask

  task automatic send(input logic [7:0] b);
    step(b, 1'b1, 1'b0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++; if (bus.di !== 4'b0000) begin tests_failed++; $display("FAIL reset_di got=%b exp=0000", bus.di); end
    tests_run++; if (bus.serve !== 1'b0) begin tests_failed++; $display("FAIL reset_serve got=%b exp=0", bus.serve); end
    tests_run++; if (bus.paused !== 1'b0) begin tests_failed++; $display("FAIL reset_paused got=%b exp=0", bus.paused); end
    tests_run++; if (bus.last_key !== 8'h00) begin tests_failed++; $display("FAIL reset_last_key got=%h exp=00", bus.last_key); end
    reset = 1'b0;
    repeat (6) step(8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_hold;
    send(8'h77);
    tests_run++; if (bus.di !== 4'b0001) begin tests_failed++; $display("FAIL hold_press_di got=%b exp=0001", bus.di); end
    tests_run++; if (bus.last_key !== 8'h77) begin tests_failed++; $display("FAIL hold_last_key got=%h exp=77", bus.last_key); end
    ticks(5);
    tests_run++; if (bus.di !== 4'b0001) begin tests_failed++; $display("FAIL hold_after5 got=%b exp=0001", bus.di); end
    step(8'h00, 1'b0, 1'b0);
    tests_run++; if (bus.di !== 4'b0001) begin tests_failed++; $display("FAIL hold_no_tick got=%b exp=0001", bus.di); end
    ticks(1);
    tests_run++; if (bus.di !== 4'b0000) begin tests_failed++; $display("FAIL hold_after6 got=%b exp=0000", bus.di); end
    ticks(2);
    tests_run++; if (bus.di !== 4'b0000) begin tests_failed++; $display("FAIL hold_idle_tick got=%b exp=0000", bus.di); end
  endtask

  task automatic test_reverse;
    send(8'h69);
    tests_run++; if (bus.di !== 4'b0100) begin tests_failed++; $display("FAIL rev_p2_up got=%b exp=0100", bus.di); end
    ticks(2);
    send(8'h4B);
    tests_run++; if (bus.di !== 4'b1000) begin tests_failed++; $display("FAIL rev_p2_dn got=%b exp=1000", bus.di); end
    tests_run++; if (bus.last_key !== 8'h4B) begin tests_failed++; $display("FAIL rev_last_key got=%h exp=4b", bus.last_key); end
    send(8'h57);
    tests_run++; if (bus.di !== 4'b1001) begin tests_failed++; $display("FAIL rev_both got=%b exp=1001", bus.di); end
    // Without the reload P2 would have expired after 4 more ticks.
    ticks(5);
    tests_run++; if (bus.di !== 4'b1001) begin tests_failed++; $display("FAIL rev_reload_hold got=%b exp=1001", bus.di); end
    ticks(1);
    tests_run++; if (bus.di !== 4'b0000) begin tests_failed++; $display("FAIL rev_expire got=%b exp=0000", bus.di); end
  endtask

  task automatic test_collision;
    send(8'h69);
    ticks(3);
    step(8'h73, 1'b1, 1'b1);
    tests_run++; if (bus.di !== 4'b0110) begin tests_failed++; $display("FAIL coll_load got=%b exp=0110", bus.di); end
    ticks(1);
    tests_run++; if (bus.di !== 4'b0110) begin tests_failed++; $display("FAIL coll_p2_cnt1 got=%b exp=0110", bus.di); end
    ticks(1);
    tests_run++; if (bus.di !== 4'b0010) begin tests_failed++; $display("FAIL coll_p2_expire got=%b exp=0010", bus.di); end
    ticks(3);
    tests_run++; if (bus.di !== 4'b0010) begin tests_failed++; $display("FAIL coll_p1_nodec got=%b exp=0010", bus.di); end
    ticks(1);
    tests_run++; if (bus.di !== 4'b0000) begin tests_failed++; $display("FAIL coll_p1_expire got=%b exp=0000", bus.di); end
  endtask

  task automatic test_pause;
    send(8'h77);
    send(8'h69);
    tests_run++; if (bus.di !== 4'b0101) begin tests_failed++; $display("FAIL pause_pre got=%b exp=0101", bus.di); end
    send(8'h70);
    tests_run++; if (bus.paused !== 1'b1) begin tests_failed++; $display("FAIL pause_enter got=%b exp=1", bus.paused); end
    tests_run++; if (bus.di !== 4'b0000) begin tests_failed++; $display("FAIL pause_di_clear got=%b exp=0000", bus.di); end
    tests_run++; if (bus.last_key !== 8'h70) begin tests_failed++; $display("FAIL pause_last_key got=%h exp=70", bus.last_key); end
    send(8'h77);
    tests_run++; if (bus.di !== 4'b0000) begin tests_failed++; $display("FAIL pause_key_ignored got=%b exp=0000", bus.di); end
    send(8'h20);
    tests_run++; if (bus.serve !== 1'b0) begin tests_failed++; $display("FAIL pause_no_serve got=%b exp=0", bus.serve); end
    tests_run++; if (bus.last_key !== 8'h70) begin tests_failed++; $display("FAIL pause_last_key_hold got=%h exp=70", bus.last_key); end
    ticks(2);
    send(8'h50);
    tests_run++; if (bus.paused !== 1'b0) begin tests_failed++; $display("FAIL pause_exit got=%b exp=0", bus.paused); end
    tests_run++; if (bus.last_key !== 8'h50) begin tests_failed++; $display("FAIL pause_exit_key got=%h exp=50", bus.last_key); end
    tests_run++; if (bus.di !== 4'b0000) begin tests_failed++; $display("FAIL pause_exit_di got=%b exp=0000", bus.di); end
  endtask

  task automatic test_serve_and_junk;
    send(8'h20);
    tests_run++; if (bus.serve !== 1'b1) begin tests_failed++; $display("FAIL serve_pulse got=%b exp=1", bus.serve); end
    tests_run++; if (bus.last_key !== 8'h20) begin tests_failed++; $display("FAIL serve_last_key got=%h exp=20", bus.last_key); end
    step(8'h00, 1'b0, 1'b0);
    tests_run++; if (bus.serve !== 1'b0) begin tests_failed++; $display("FAIL serve_one_clk got=%b exp=0", bus.serve); end
    send(8'h78);
    send(8'h00);
    send(8'hFF);
    tests_run++; if (bus.last_key !== 8'h20) begin tests_failed++; $display("FAIL junk_last_key got=%h exp=20", bus.last_key); end
    tests_run++; if (bus.di !== 4'b0000) begin tests_failed++; $display("FAIL junk_di got=%b exp=0000", bus.di); end
    tests_run++; if (bus.paused !== 1'b0 || bus.serve !== 1'b0) begin tests_failed++; $display("FAIL junk_ctrl got paused=%b serve=%b exp 0 0", bus.paused, bus.serve); end
  endtask

  task automatic test_async_reset;
    send(8'h53);
    ticks(1);
    tests_run++; if (bus.di !== 4'b0010) begin tests_failed++; $display("FAIL areset_pre got=%b exp=0010", bus.di); end
    #2;
    reset = 1'b1;
    #1;
    tests_run++; if (bus.di !== 4'b0000) begin tests_failed++; $display("FAIL areset_di got=%b exp=0000", bus.di); end
    tests_run++; if (bus.last_key !== 8'h00 || bus.paused !== 1'b0) begin tests_failed++; $display("FAIL areset_regs got last_key=%h paused=%b exp 00 0", bus.last_key, bus.paused); end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    ticks(7);
    tests_run++; if (bus.di !== 4'b0000) begin tests_failed++; $display("FAIL areset_after_ticks got=%b exp=0000", bus.di); end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.tick     = 1'b0;
    #1;
    test_reset();
    test_hold();
    test_reverse();
    test_collision();
    test_pause();
    test_serve_and_junk();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
